// File: rtl/placar_pkg.sv
// placar_pkg: shared FSM states, segment codes, digit indices and BCD helpers for the score display
package placar_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
    localparam int BCD_W = 4;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [1:0] DIG_U = 2'd0;
    localparam logic [1:0] DIG_T = 2'd1;
    localparam logic [1:0] DIG_H = 2'd2;
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
        return d >= 4'd5 ? d + 4'd3 : d;
    endfunction
endpackage

// File: rtl/placar_display_7seg_if.sv
// placar_display_7seg_if: score input and multiplexed 7-segment outputs of the display stage
interface placar_display_7seg_if;
    logic [6:0] tot;
    logic [6:0] seg;
    logic [2:0] an;
    logic       busy;
    modport master (output tot, input seg, an, busy);
    modport slave  (input tot, output seg, an, busy);
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: BCD digit to active-high {g,f,e,d,c,b,a} segments; codes 10-15 decode to blank
module seg7_decoder
    import placar_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/placar_display_7seg.sv
// placar_display_7seg: shift-add-3 BCD conversion of the score total and 3-digit 7-segment scan;
// define PLACAR_LEADING_ZERO_BLANK_EN to blank leading zeros on the hundreds and tens digits.
module placar_display_7seg
    import placar_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    placar_display_7seg_if.slave bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [2:0] AN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    state_e           state_q, state_d;
    logic [6:0]       last_q, last_d;
    logic [18:0]      sr_q, sr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0] d_h_q, d_h_d, d_t_q, d_t_d, d_u_q, d_u_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] scan_q, scan_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [11:0]      adj;
    logic             wrap, blank;
    logic [BCD_W-1:0] dig;
    logic [2:0]       onehot;
    logic [6:0]       dec_seg;

    seg7_decoder u_dec (.bcd(dig), .seg(dec_seg));

    // Digits are corrected independently so a >=5 digit never carries into its neighbour
    assign adj = {add3(sr_q[18:15]), add3(sr_q[14:11]), add3(sr_q[10:7])};

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        d_h_d   = d_h_q;
        d_t_d   = d_t_q;
        d_u_d   = d_u_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: if (bus.tot != last_q) begin
                sr_d    = {sr_q[18:7], bus.tot};
                last_d  = bus.tot;
                busy_d  = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                sr_d    = {12'd0, sr_q[6:0]};
                cnt_d   = 3'd7;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d    = {adj, sr_q[6:0]} << 1;
                cnt_d   = cnt_q - 3'd1;
                state_d = cnt_q == 3'd1 ? DONE : SHIFT;
            end
            DONE: begin
                d_h_d   = sr_q[18:15];
                d_t_d   = sr_q[14:11];
                d_u_d   = sr_q[10:7];
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wrap   = scan_q == CNT_W'(REFRESH_DIV - 1);
        scan_d = wrap ? '0 : scan_q + CNT_W'(1);
        idx_d  = wrap ? (idx_q == DIG_H ? DIG_U : idx_q + 2'd1) : idx_q;
`ifdef PLACAR_LEADING_ZERO_BLANK_EN
        blank  = (idx_q == DIG_H && d_h_q == '0) || (idx_q == DIG_T && d_h_q == '0 && d_t_q == '0);
`else
        blank  = 1'b0;
`endif
        // Code 15 decodes to blank, so blanking reuses the single decoder
        dig    = blank ? 4'hF : idx_q == DIG_H ? d_h_q : idx_q == DIG_T ? d_t_q : d_u_q;
        onehot = idx_q == DIG_H ? 3'b100 : idx_q == DIG_T ? 3'b010 : 3'b001;
        an_d   = SEG_ACTIVE_LOW ? ~onehot : onehot;
        seg_d  = SEG_ACTIVE_LOW ? ~dec_seg : dec_seg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            d_h_q   <= '0;
            d_t_q   <= '0;
            d_u_q   <= '0;
            busy_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= DIG_U;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            d_h_q   <= d_h_d;
            d_t_q   <= d_t_d;
            d_u_q   <= d_u_d;
            busy_q  <= busy_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_placar_display_7seg.sv
// tb_placar_display_7seg: directed checks of conversion, scan, blanking and reset of the score display
module tb_placar_display_7seg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    placar_display_7seg_if bus_if ();

    placar_display_7seg #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

`ifdef PLACAR_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZERO_LEAD = 7'h7F;
`else
    localparam logic [6:0] ZERO_LEAD = 7'h40;
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic find_digit(input logic [2:0] a, output logic [6:0] s, output bit ok);
        ok = 1'b0;
        s  = 'x;
        for (int i = 0; i < 16 && !ok; i++) begin
            tick();
            if (bus_if.an === a) begin
                s  = bus_if.seg;
                ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus_if.tot = 7'd0;
        tick();
        tick();
        checks++; if (bus_if.an !== 3'b111) begin errors++; $display("FAIL reset_an: got %b expected %b", bus_if.an, 3'b111); end
        checks++; if (bus_if.seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected %h", bus_if.seg, 7'h7F); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        rst = 1'b1;
        tick();
        checks++; if (bus_if.an !== 3'b110) begin errors++; $display("FAIL release_an: got %b expected %b", bus_if.an, 3'b110); end
        checks++; if (bus_if.seg !== 7'h40) begin errors++; $display("FAIL release_seg: got %h expected %h", bus_if.seg, 7'h40); end
    endtask

    task automatic test_conversion;
        int n;
        logic [6:0] s;
        bit ok;
        bus_if.tot = 7'd127;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus_if.busy === 1'b1) n++;
            else break;
        end
        checks++; if (n != 9) begin errors++; $display("FAIL conv_busy_len: got %0d expected 9", n); end
        find_digit(3'b011, s, ok);
        checks++; if (!ok || s !== 7'h79) begin errors++; $display("FAIL conv127_h: got %h expected %h", s, 7'h79); end
        find_digit(3'b101, s, ok);
        checks++; if (!ok || s !== 7'h24) begin errors++; $display("FAIL conv127_t: got %h expected %h", s, 7'h24); end
        find_digit(3'b110, s, ok);
        checks++; if (!ok || s !== 7'h78) begin errors++; $display("FAIL conv127_u: got %h expected %h", s, 7'h78); end
    endtask

    task automatic test_mid_change;
        logic [6:0] s;
        bit ok;
        bus_if.tot = 7'd45;
        repeat (3) tick();
        bus_if.tot = 7'd46;
        repeat (7) tick();
        checks++; if ({dut.d_h_q, dut.d_t_q, dut.d_u_q} !== 12'h045) begin errors++; $display("FAIL mid_first: got %h expected 045", {dut.d_h_q, dut.d_t_q, dut.d_u_q}); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL mid_first_busy: got %b expected 0", bus_if.busy); end
        tick();
        checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL mid_restart_busy: got %b expected 1", bus_if.busy); end
        repeat (9) tick();
        checks++; if ({dut.d_h_q, dut.d_t_q, dut.d_u_q} !== 12'h046) begin errors++; $display("FAIL mid_final: got %h expected 046", {dut.d_h_q, dut.d_t_q, dut.d_u_q}); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL mid_final_busy: got %b expected 0", bus_if.busy); end
        find_digit(3'b110, s, ok);
        checks++; if (!ok || s !== 7'h02) begin errors++; $display("FAIL mid46_u: got %h expected %h", s, 7'h02); end
        find_digit(3'b101, s, ok);
        checks++; if (!ok || s !== 7'h19) begin errors++; $display("FAIL mid46_t: got %h expected %h", s, 7'h19); end
    endtask

    task automatic test_blanking;
        logic [6:0] s;
        bit ok;
        bus_if.tot = 7'd7;
        repeat (10) tick();
        find_digit(3'b011, s, ok);
        checks++; if (!ok || s !== ZERO_LEAD) begin errors++; $display("FAIL blank_h: got %h expected %h", s, ZERO_LEAD); end
        find_digit(3'b101, s, ok);
        checks++; if (!ok || s !== ZERO_LEAD) begin errors++; $display("FAIL blank_t: got %h expected %h", s, ZERO_LEAD); end
        find_digit(3'b110, s, ok);
        checks++; if (!ok || s !== 7'h78) begin errors++; $display("FAIL blank_u: got %h expected %h", s, 7'h78); end
    endtask

    task automatic test_scan_wrap;
        logic [6:0] s;
        logic [2:0] prev, want;
        bit ok;
        int n, total;
        bus_if.tot = 7'd123;
        repeat (10) tick();
        find_digit(3'b011, s, ok);
        checks++; if (!ok || s !== 7'h79) begin errors++; $display("FAIL scan123_h: got %h expected %h", s, 7'h79); end
        find_digit(3'b101, s, ok);
        checks++; if (!ok || s !== 7'h24) begin errors++; $display("FAIL scan123_t: got %h expected %h", s, 7'h24); end
        find_digit(3'b110, s, ok);
        checks++; if (!ok || s !== 7'h30) begin errors++; $display("FAIL scan123_u: got %h expected %h", s, 7'h30); end
        prev = bus_if.an;
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            tick();
            ok = bus_if.an !== prev;
        end
        checks++; if (!ok) begin errors++; $display("FAIL scan_first_change: got no change expected change within 16 cycles"); end
        total = 0;
        for (int k = 0; k < 3; k++) begin
            prev = bus_if.an;
            want = prev == 3'b110 ? 3'b101 : prev == 3'b101 ? 3'b011 : 3'b110;
            n = 0;
            for (int i = 0; i < 16; i++) begin
                tick();
                n++;
                if (bus_if.an !== prev) break;
            end
            total += n;
            checks++; if (n != 4) begin errors++; $display("FAIL scan_dwell%0d: got %0d expected 4", k, n); end
            checks++; if (bus_if.an !== want) begin errors++; $display("FAIL scan_order%0d: got %b expected %b", k, bus_if.an, want); end
        end
        checks++; if (total != 12) begin errors++; $display("FAIL scan_period: got %0d expected 12", total); end
    endtask

    task automatic test_reset_mid;
        logic [6:0] s;
        bit ok;
        bus_if.tot = 7'd99;
        repeat (5) tick();
        checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", bus_if.busy); end
        rst = 1'b0;
        #1;
        checks++; if (bus_if.an !== 3'b111) begin errors++; $display("FAIL rmid_an: got %b expected %b", bus_if.an, 3'b111); end
        checks++; if (bus_if.seg !== 7'h7F) begin errors++; $display("FAIL rmid_seg: got %h expected %h", bus_if.seg, 7'h7F); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", bus_if.busy); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL rmid_restart_busy: got %b expected 1", bus_if.busy); end
        checks++; if (bus_if.an !== 3'b110 || bus_if.seg !== 7'h40) begin errors++; $display("FAIL rmid_first_out: got %b/%h expected 110/40", bus_if.an, bus_if.seg); end
        repeat (9) tick();
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL rmid_done_busy: got %b expected 0", bus_if.busy); end
        find_digit(3'b110, s, ok);
        checks++; if (!ok || s !== 7'h10) begin errors++; $display("FAIL rmid99_u: got %h expected %h", s, 7'h10); end
        find_digit(3'b101, s, ok);
        checks++; if (!ok || s !== 7'h10) begin errors++; $display("FAIL rmid99_t: got %h expected %h", s, 7'h10); end
        find_digit(3'b011, s, ok);
        checks++; if (!ok || s !== ZERO_LEAD) begin errors++; $display("FAIL rmid99_h: got %h expected %h", s, ZERO_LEAD); end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_mid_change();
        test_blanking();
        test_scan_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/placar_display_7seg.md
# placar_display_7seg

- Downstream stage of the scoreboard point accumulator.
- Consumes the 7-bit running total `tot` (0–127) and converts it to three BCD digits with a sequential shift-add-3 engine.
- Drives a time-multiplexed 3-digit 7-segment display: hundreds, tens and units.
- Re-converts automatically whenever the total changes, so the display follows every score update without a handshake from the accumulator.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled before the scan advances; legal range ≥ 2.
- `SEG_ACTIVE_LOW`, default 1: 1 means segment and anode outputs are active-low, 0 means active-high.
- `clk` input 1: single system clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `tot` input 7: binary score from the accumulator; may change on any cycle.
- `seg` output 7: segment drive, ordered {g,f,e,d,c,b,a}; registered.
- `an` output 3: digit enables, bit0 = units, bit1 = tens, bit2 = hundreds; registered.
- `busy` output 1: high while a conversion is in progress; registered.

## Operation
- Conversion FSM has four states:
  - IDLE: compare `tot` with `last_val`. If they differ, capture `tot` into the shift register and `last_val`, then go to LOAD. Otherwise stay in IDLE.
  - LOAD: clear the 12-bit BCD field (3×4 bits); set the shift counter to 7; go to SHIFT.
  - SHIFT: one iteration per cycle. First add 3 to every BCD digit ≥ 5. Then shift the 19-bit {bcd, bin} register left by 1 and decrement the counter. When the counter reaches 0, go to DONE.
  - DONE: copy the BCD field into the display digit registers `d_h`, `d_t`, `d_u`; go to IDLE.
- Arithmetic and width rules:
  - The hundreds digit is never greater than 1.
  - Add-3 is applied per 4-bit digit and never carries between digits.
  - The binary part is exactly 7 bits.
- `tot` changing during LOAD/SHIFT/DONE is ignored until IDLE. The next IDLE cycle then detects the mismatch and starts a new conversion, so the final displayed value always equals the most recent stable `tot`.
- Scan logic:
  - A free-running counter `scan_cnt` counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→2→0.
- Each cycle, the `an`/`seg` registers load the selected digit's one-hot enable and its decoded segments.
- Polarity is applied at the output: when `SEG_ACTIVE_LOW` = 1, `an` and `seg` are inverted.
- Segment codes, with 1 meaning lit:
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66
  - 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F
  - blank = 0x00

## Timing
- Reset values, with `rst` low: state IDLE, `last_val` = 0, `d_h`/`d_t`/`d_u` = 0, `scan_cnt` = 0, digit index = 0, `busy` = 0.
- Outputs under reset: `an` all inactive and `seg` blank, i.e. `an` = 3'b111 and `seg` = 7'h7F when `SEG_ACTIVE_LOW` = 1.
- First edge after reset release: `an` enables units and `seg` shows `d_u` (0).
- Conversion latency:
  - Edge 0 is the IDLE edge that sees `tot` ≠ `last_val`.
  - Edge 1: LOAD. Edges 2–8: SHIFT. Edge 9: DONE writes the digit registers.
  - The new digit reaches `seg` at edge 10 when it is the selected digit.
- `busy` is 1 after edges 0–8 and returns to 0 after edge 9.
- Minimum spacing between back-to-back conversions is 10 cycles.
- `rst` asserted mid-conversion aborts immediately; all registers return to reset values.
- After reset release with `tot` ≠ 0, a conversion starts on the first edge.

## Configuration
- Macro `PLACAR_LEADING_ZERO_BLANK_EN`:
  - Defined: hundreds digit is blank when `d_h` = 0. Tens digit is blank when `d_h` = 0 and `d_t` = 0. Units digit is never blank.
  - Undefined: all three digits are always shown, e.g. 005.
- Blanking acts on the display registers only; conversion behaviour is unchanged.

## Structure
- Shared package/include `placar_pkg`:
  - FSM state encodings (IDLE, LOAD, SHIFT, DONE)
  - SEG_0..SEG_9 and SEG_BLANK constants
  - digit-index constants
  - BCD width constant (4)
- One sub-module, `seg7_decoder`: purely combinational 4-bit BCD in to 7-bit active-high segments out. Inputs 10–15 decode to blank. Instantiated once, fed by the digit-select mux.

## Test plan
- Reset: hold `rst` low with `tot` = 0 → `an` = 3'b111, `seg` = 7'h7F, `busy` = 0. One cycle after release → `an` = 3'b110, `seg` = ~0x3F.
- Conversion: `tot` 0→127, `REFRESH_DIV` = 4 → `busy` high for exactly 9 cycles; digits become 1, 2, 7; one scan cycle shows ~0x06, ~0x5B, ~0x07 on `an` 011, 101, 110.
- Mid-conversion change: `tot` = 45, then `tot` = 46 three cycles later → first conversion completes showing 0,4,5 for one cycle. A second conversion starts on the next IDLE edge; final digits are 0,4,6 at 19 cycles after the first change.
- Blanking: `tot` = 7 with macro defined → hundreds and tens show blank, units ~0x07. With the macro undefined → ~0x3F, ~0x3F, ~0x07.
- Scan wrap: `REFRESH_DIV` = 4, `tot` = 123 → digit index changes every 4 cycles, sequence units→tens→hundreds→units, period 12 cycles.
- Reset mid-conversion: `tot` = 99, assert `rst` at the 4th SHIFT cycle → all outputs return to reset values immediately. After release, conversion restarts and 0,9,9 appears 10 cycles after the first post-reset edge.
